// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Fixed-priority pick: data wins unless fetch has been starved to the limit.
module arb_pick (
    input  logic if_req,
    input  logic d_req,
    input  logic starve_full,
    output logic grant_if,
    output logic grant_d
);

    // Winner selection for one arbitration cycle
    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (d_req && !(if_req && starve_full)) begin
            grant_d = 1'b1;
        end else if (if_req) begin
            grant_if = 1'b1;
        end else begin
            grant_if = 1'b0;
            grant_d  = 1'b0;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between instruction fetch and the load/store unit.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [1:0]        d_size,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read_write,
    output logic [DATA_W-1:0] mem_data_in,
    output logic [1:0]        mem_access_size,
    input  logic [DATA_W-1:0] mem_data_out
);

    localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LATENCY - 1);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    logic [STV_W-1:0]    starve_q, starve_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [1:0]          size_q, size_d;
    logic                if_rvalid_q, if_rvalid_d;
    logic                d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_rw_q, mem_rw_d;

    logic                arb_ok_s;
    logic                pick_if_s;
    logic                pick_d_s;

    arb_pick u_arb_pick (
        .if_req      (if_req),
        .d_req       (d_req),
        .starve_full (starve_q == STV_MAX),
        .grant_if    (pick_if_s),
        .grant_d     (pick_d_s)
    );

    // Grants are only offered while arbitrating and never during reset
    assign arb_ok_s = !reset && ((state_q == IDLE) || (state_q == RESP));
    assign if_gnt   = arb_ok_s && pick_if_s;
    assign d_gnt    = arb_ok_s && pick_d_s;

    // Next-state, access latching and response capture
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        starve_d    = starve_q;
        lat_d       = lat_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        size_d      = size_q;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        case (state_q)
            IDLE, RESP: begin
                if (if_gnt) begin
                    state_d  = BUSY;
                    owner_d  = OWN_IF;
                    addr_d   = if_addr;
                    we_d     = MEM_READ;
                    wdata_d  = {DATA_W{1'b0}};
                    size_d   = SIZE_WORD;
                    lat_d    = {LAT_W{1'b0}};
                    starve_d = {STV_W{1'b0}};
                end else if (d_gnt) begin
                    state_d  = BUSY;
                    owner_d  = OWN_D;
                    addr_d   = d_addr;
                    we_d     = d_we;
                    wdata_d  = d_wdata;
                    size_d   = d_size;
                    lat_d    = {LAT_W{1'b0}};
                    if (if_req && (starve_q != STV_MAX)) begin
                        starve_d = starve_q + STV_W'(1);
                    end else begin
                        starve_d = starve_q;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (lat_q == LAT_LAST) begin
                    state_d = RESP;
                    lat_d   = {LAT_W{1'b0}};
                    if (owner_q == OWN_IF) begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = mem_data_out;
                    end else begin
                        d_rvalid_d = 1'b1;
                        d_rdata_d  = (we_q == MEM_WRITE) ? {DATA_W{1'b0}} : mem_data_out;
                    end
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        mem_en_d = (state_d == BUSY);
        mem_rw_d = (state_d == BUSY) && (we_d == MEM_WRITE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            starve_q    <= {STV_W{1'b0}};
            lat_q       <= {LAT_W{1'b0}};
            addr_q      <= {ADDR_W{1'b0}};
            we_q        <= MEM_READ;
            wdata_q     <= {DATA_W{1'b0}};
            size_q      <= SIZE_BYTE;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= {DATA_W{1'b0}};
            d_rdata_q   <= {DATA_W{1'b0}};
            mem_en_q    <= 1'b0;
            mem_rw_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            starve_q    <= starve_d;
            lat_q       <= lat_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            size_q      <= size_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            mem_en_q    <= mem_en_d;
            mem_rw_q    <= mem_rw_d;
        end
    end

    assign if_rvalid       = if_rvalid_q;
    assign if_rdata        = if_rdata_q;
    assign d_rvalid        = d_rvalid_q;
    assign d_rdata         = d_rdata_q;
    assign mem_en          = mem_en_q;
    assign mem_read_write  = mem_rw_q;
    assign mem_address     = addr_q;
    assign mem_data_in     = wdata_q;
    assign mem_access_size = size_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench: one arbiter at MEM_LATENCY=1, a second at MEM_LATENCY=3 for back-to-back spacing.
module tb_mem_arbiter;

    typedef struct {
        logic [31:0] addr;
        logic        rw;
        logic [31:0] wdata;
        logic [1:0]  size;
    } macc_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int cmp_cnt = 0;
    int err_cnt = 0;
    bit mon_on  = 1'b0;

    // DUT with MEM_LATENCY=1
    logic        reset, if_req, if_gnt, if_rvalid, d_req, d_we, d_gnt, d_rvalid;
    logic        mem_en, mem_read_write;
    logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, mem_address, mem_data_in, mem_data_out;
    logic [1:0]  d_size, mem_access_size;

    // DUT with MEM_LATENCY=3
    logic        reset3, if_req3, if_gnt3, if_rvalid3, d_req3, d_we3, d_gnt3, d_rvalid3;
    logic        mem_en3, mem_read_write3;
    logic [31:0] if_addr3, if_rdata3, d_addr3, d_wdata3, d_rdata3, mem_address3, mem_data_in3, mem_data_out3;
    logic [1:0]  d_size3, mem_access_size3;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .STARVE_LIMIT(4)) dut (
        .clock(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_address(mem_address), .mem_read_write(mem_read_write),
        .mem_data_in(mem_data_in), .mem_access_size(mem_access_size), .mem_data_out(mem_data_out)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3), .STARVE_LIMIT(4)) dut3 (
        .clock(clk), .reset(reset3),
        .if_req(if_req3), .if_addr(if_addr3), .if_gnt(if_gnt3), .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
        .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3), .d_size(d_size3),
        .d_gnt(d_gnt3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
        .mem_en(mem_en3), .mem_address(mem_address3), .mem_read_write(mem_read_write3),
        .mem_data_in(mem_data_in3), .mem_access_size(mem_access_size3), .mem_data_out(mem_data_out3)
    );

    // Word-indexed memory models, reloaded whenever their arbiter is in reset
    logic [31:0] mem1 [256];
    logic [31:0] mem3 [256];
    assign mem_data_out  = mem1[mem_address[9:2]];
    assign mem_data_out3 = mem3[mem_address3[9:2]];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem1[i] <= 32'h0;
            mem1[0] <= 32'h0000_0013;
        end else if (mem_en && mem_read_write) begin
            mem1[mem_address[9:2]] <= mem_data_in;
        end
    end

    always @(posedge clk) begin
        if (reset3) begin
            for (int i = 0; i < 256; i++) mem3[i] <= 32'h0;
            mem3[8'h40] <= 32'h1111_1111;
            mem3[8'h41] <= 32'h2222_2222;
        end else if (mem_en3 && mem_read_write3) begin
            mem3[mem_address3[9:2]] <= mem_data_in3;
        end
    end

    logic        exp_gnt [$];
    logic [31:0] exp_ifd [$];
    logic [31:0] exp_dd  [$];
    macc_t       exp_mem [$];
    int          exp_rvc [$];
    logic [31:0] exp_d3  [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor for the latency-1 arbiter
    logic mem_en_prev = 1'b0;
    always @(negedge clk) begin : mon1
        macc_t m;
        if (mon_on) begin
            if (if_gnt || d_gnt) begin
                chk("one_gnt", 32'(if_gnt && d_gnt), 32'd0);
                chk("gnt_not_busy", 32'(mem_en), 32'd0);
                if (exp_gnt.size() == 0) chk("unexpected_gnt", 32'd1, 32'd0);
                else chk("gnt_owner_is_if", 32'(if_gnt), 32'(exp_gnt.pop_front()));
                exp_rvc.push_back(cyc + 2);
            end
            if (mem_en && !mem_en_prev) begin
                if (exp_mem.size() == 0) chk("unexpected_mem_access", 32'd1, 32'd0);
                else begin
                    m = exp_mem.pop_front();
                    chk("mem_address", mem_address, m.addr);
                    chk("mem_read_write", 32'(mem_read_write), 32'(m.rw));
                    chk("mem_access_size", 32'(mem_access_size), 32'(m.size));
                    if (m.rw) chk("mem_data_in", mem_data_in, m.wdata);
                end
            end
            if (if_rvalid) begin
                if (exp_ifd.size() == 0) chk("unexpected_if_rvalid", 32'd1, 32'd0);
                else chk("if_rdata", if_rdata, exp_ifd.pop_front());
            end
            if (d_rvalid) begin
                if (exp_dd.size() == 0) chk("unexpected_d_rvalid", 32'd1, 32'd0);
                else chk("d_rdata", d_rdata, exp_dd.pop_front());
            end
            if (if_rvalid || d_rvalid) begin
                if (exp_rvc.size() == 0) chk("unexpected_rvalid_timing", 32'd1, 32'd0);
                else chk("rvalid_cycle", 32'(cyc), 32'(exp_rvc.pop_front()));
            end
        end
        mem_en_prev <= mem_en;
    end

    // Monitor for the latency-3 arbiter
    int last_rv3 = -1;
    always @(negedge clk) begin : mon3
        if (mon_on && d_rvalid3) begin
            if (exp_d3.size() == 0) chk("unexpected_d_rvalid3", 32'd1, 32'd0);
            else chk("d_rdata3", d_rdata3, exp_d3.pop_front());
            if (last_rv3 >= 0) chk("b2b_rvalid_spacing", 32'(cyc - last_rv3), 32'd4);
            last_rv3 <= cyc;
        end
    end

    task automatic wait_gnt(input bit want_if);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = want_if ? if_gnt : d_gnt;
        end
        if (!seen) chk("gnt_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic fetch1(input logic [31:0] a, input logic [31:0] data);
        exp_gnt.push_back(1'b1);
        exp_ifd.push_back(data);
        exp_mem.push_back('{a, 1'b0, 32'h0, 2'd2});
        if_req = 1'b1; if_addr = a;
        wait_gnt(1'b1);
        if_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic data1(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [1:0] sz, input logic [31:0] data);
        exp_gnt.push_back(1'b0);
        exp_dd.push_back(data);
        exp_mem.push_back('{a, we, wd, sz});
        d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; d_size = sz;
        wait_gnt(1'b0);
        d_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_if_gnt"}, 32'(if_gnt), 32'd0);
        chk({tag, "_d_gnt"}, 32'(d_gnt), 32'd0);
        chk({tag, "_if_rvalid"}, 32'(if_rvalid), 32'd0);
        chk({tag, "_d_rvalid"}, 32'(d_rvalid), 32'd0);
        chk({tag, "_mem_en"}, 32'(mem_en), 32'd0);
        chk({tag, "_mem_rw"}, 32'(mem_read_write), 32'd0);
        chk({tag, "_mem_address"}, mem_address, 32'd0);
        chk({tag, "_mem_data_in"}, mem_data_in, 32'd0);
        chk({tag, "_mem_size"}, 32'(mem_access_size), 32'd0);
        chk({tag, "_if_rdata"}, if_rdata, 32'd0);
        chk({tag, "_d_rdata"}, d_rdata, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit seen;
        reset = 1'b1; if_req = 1'b0; if_addr = 32'h0; d_req = 1'b0; d_we = 1'b0;
        d_addr = 32'h0; d_wdata = 32'h0; d_size = 2'd0;
        reset3 = 1'b1; if_req3 = 1'b0; if_addr3 = 32'h0; d_req3 = 1'b0; d_we3 = 1'b0;
        d_addr3 = 32'h0; d_wdata3 = 32'h0; d_size3 = 2'd0;
        @(posedge clk); #1;
        mon_on = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; reset3 = 1'b0;
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;

        fetch1(32'h0100_0000, 32'h0000_0013);
        data1(1'b1, 32'h0100_0100, 32'hDEAD_BEEF, 2'd2, 32'h0);
        data1(1'b0, 32'h0100_0100, 32'h0, 2'd2, 32'hDEAD_BEEF);
        data1(1'b1, 32'h0100_0203, 32'h0000_00AB, 2'd0, 32'h0);

        // Contention: D,D,D,D,IF twice with both requests held
        for (int k = 0; k < 10; k++) begin
            if (k % 5 == 4) begin
                exp_gnt.push_back(1'b1);
                exp_ifd.push_back(32'h0000_0013);
                exp_mem.push_back('{32'h0100_0000, 1'b0, 32'h0, 2'd2});
            end else begin
                exp_gnt.push_back(1'b0);
                exp_dd.push_back(32'hDEAD_BEEF);
                exp_mem.push_back('{32'h0100_0100, 1'b0, 32'h0, 2'd2});
            end
        end
        if_req = 1'b1; if_addr = 32'h0100_0000;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0100_0100; d_wdata = 32'h0; d_size = 2'd2;
        n = 0;
        for (int i = 0; i < 100 && n < 10; i++) begin
            @(negedge clk);
            if (if_gnt || d_gnt) n++;
        end
        if (n < 10) chk("contention_gnt_count", 32'(n), 32'd10);
        @(posedge clk); #1;
        if_req = 1'b0; d_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset during the BUSY cycle of a store abandons it
        exp_gnt.push_back(1'b0);
        exp_mem.push_back('{32'h0100_0300, 1'b1, 32'h55AA_55AA, 2'd2});
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0100_0300; d_wdata = 32'h55AA_55AA; d_size = 2'd2;
        wait_gnt(1'b0);
        d_req = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        if (exp_rvc.size() > 0) void'(exp_rvc.pop_back());
        @(negedge clk);
        chk_all_zero("after_reset_busy");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_rvalid_after_reset", 32'(d_rvalid), 32'd0);
        end
        @(posedge clk); #1;

        // Back-to-back loads on the latency-3 arbiter
        exp_d3.push_back(32'h1111_1111);
        exp_d3.push_back(32'h2222_2222);
        d_req3 = 1'b1; d_we3 = 1'b0; d_addr3 = 32'h0000_0100; d_size3 = 2'd2;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = d_gnt3;
        end
        if (!seen) chk("gnt3_first_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        d_addr3 = 32'h0000_0104;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = d_gnt3;
        end
        if (!seen) chk("gnt3_second_timeout", 32'd0, 32'd1);
        else chk("b2b_gnt_in_resp", 32'(d_rvalid3), 32'd1);
        @(posedge clk); #1;
        d_req3 = 1'b0;
        repeat (8) @(posedge clk);
        #1;

        chk("left_gnt", 32'(exp_gnt.size()), 32'd0);
        chk("left_if_data", 32'(exp_ifd.size()), 32'd0);
        chk("left_d_data", 32'(exp_dd.size()), 32'd0);
        chk("left_mem", 32'(exp_mem.size()), 32'd0);
        chk("left_rvalid_timing", 32'(exp_rvc.size()), 32'd0);
        chk("left_d3_data", 32'(exp_d3.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-ported memory between the fetch requester (PC/instruction fetch) and the data requester (load/store unit), replacing separate imemory/dmemory ports in the next processor revision. Per access it runs a request/grant/response handshake with each side, drives the memory port for a fixed latency, and returns read data. Data accesses win ties; a starvation counter guarantees fetch progress.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LATENCY, 1, cycles from memory address sample to valid mem_data_out (≥1)
- STARVE_LIMIT, 4, consecutive data grants taken while fetch waits before fetch is forced (≥1)

Ports (one clock; reset is synchronous and active-high):
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  one-cycle pulse, if_rdata valid
- if_rdata  out  DATA_W  instruction word
- d_req  in  1  data request; held with all d_* until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_size  in  2  0 byte, 1 half, 2 word
- d_gnt  out  1  data accepted this cycle
- d_rvalid  out  1  one-cycle pulse; load data valid or store complete
- d_rdata  out  DATA_W  load data (0 for stores)
- mem_en  out  1  memory access active
- mem_address  out  ADDR_W  to memory
- mem_read_write  out  1  0 read, 1 write
- mem_data_in  out  DATA_W  store data to memory
- mem_access_size  out  2  d_size for data, 2 for fetch
- mem_data_out  in  DATA_W  read data from memory

## Operation
- FSM: IDLE, BUSY, RESP.
- IDLE/RESP (arbitrating): if any req, pick winner, assert its gnt combinationally same cycle, latch owner/addr/we/wdata/size, go BUSY; else go/stay IDLE.
- Priority: d_req wins unless starve_cnt == STARVE_LIMIT, then fetch wins. Only one requester → it wins.
- starve_cnt: +1 when data granted while if_req high; cleared when fetch granted; saturates at STARVE_LIMIT.
- BUSY: mem_en=1, mem_* from latched fields, lat_cnt counts MEM_LATENCY cycles; on last cycle capture mem_data_out, go RESP.
- RESP: owner's rvalid=1 for exactly this cycle with captured data; may grant next request same cycle (back-to-back).
- Fetch is always read, size 2; if_we does not exist.
- Outside BUSY, mem_en=0, mem_read_write=0, other mem_* hold latched values (don't care).
- gnt never asserted in BUSY; at most one gnt per cycle.

## Timing
- Reset values: state IDLE, starve_cnt 0, lat_cnt 0, all gnt/rvalid/mem_en/mem_read_write 0, rdata and mem_* 0.
- Grant in cycle T → BUSY T+1..T+MEM_LATENCY → rvalid T+MEM_LATENCY+1.
- Peak throughput: one access per MEM_LATENCY+1 cycles.
- Reset mid-BUSY/RESP: access abandoned, no rvalid issued, counters cleared; requesters must reissue.
- req dropping before gnt: legal, no access. Input changes after gnt ignored.
- Simultaneous req in RESP: arbitration uses starve_cnt value before the RESP-cycle update.

## Structure
- Package mem_arb_pkg: state enum (IDLE/BUSY/RESP), size constants (SIZE_BYTE/HALF/WORD), MEM_READ=0/MEM_WRITE=1, owner enum (OWN_IF/OWN_D).
- One combinational sub-module arb_pick: inputs if_req, d_req, starve_cnt==STARVE_LIMIT; outputs grant_if, grant_d.

## Test plan
- Fetch only, MEM_LATENCY=1: if_req addr 0x01000000 at T → if_gnt at T, mem_en T+1 with address 0x01000000 read, if_rvalid T+2 with mem word 0x00000013.
- Store then load: d_we=1, addr 0x01000100, wdata 0xDEADBEEF, size 2 → mem_read_write=1, d_rvalid rdata 0; load same addr → d_rdata 0xDEADBEEF.
- Contention: if_req and d_req held continuously, STARVE_LIMIT=4 → grant order D,D,D,D,IF, repeating; starve_cnt resets after IF.
- Back-to-back: new d_req present in RESP cycle → d_gnt in RESP, next rvalid exactly MEM_LATENCY+1 later; MEM_LATENCY=3 run checks 4-cycle spacing.
- Reset in BUSY: reset high one cycle during data access → no d_rvalid, all outputs 0 next cycle, state IDLE.
- Byte store: d_size=0, addr 0x01000203 → mem_access_size=0, mem_address 0x01000203 passed unchanged.
